// File: rtl/tl_pkg.sv
// Shared types and constants for the intersection light-head safety monitor.
package tl_pkg;

    localparam int unsigned LW = 3;
    localparam int unsigned NUM_HEADS = 4;

    localparam logic [LW-1:0] LT_GREEN  = 3'b001;
    localparam logic [LW-1:0] LT_YELLOW = 3'b010;
    localparam logic [LW-1:0] LT_RED    = 3'b100;

    typedef enum logic [1:0] {
        HEAD_M1 = 2'd0,
        HEAD_M2 = 2'd1,
        HEAD_MT = 2'd2,
        HEAD_S  = 2'd3
    } head_e;

    typedef enum logic [2:0] {
        FC_NONE      = 3'd0,
        FC_ILLEGAL   = 3'd1,
        FC_CONFLICT  = 3'd2,
        FC_TRANS     = 3'd3,
        FC_YEL_SHORT = 3'd4,
        FC_YEL_LONG  = 3'd5,
        FC_STUCK     = 3'd6
    } fault_e;

    typedef struct packed {
        logic [LW-1:0] m1;
        logic [LW-1:0] m2;
        logic [LW-1:0] mt;
        logic [LW-1:0] s;
    } heads_t;

    localparam logic [2:0] PHASE_NONE = 3'd7;

    localparam heads_t PH0 = '{m1: LT_GREEN,  m2: LT_GREEN,  mt: LT_RED,    s: LT_RED};
    localparam heads_t PH1 = '{m1: LT_GREEN,  m2: LT_YELLOW, mt: LT_RED,    s: LT_RED};
    localparam heads_t PH2 = '{m1: LT_GREEN,  m2: LT_RED,    mt: LT_GREEN,  s: LT_RED};
    localparam heads_t PH3 = '{m1: LT_YELLOW, m2: LT_RED,    mt: LT_YELLOW, s: LT_RED};
    localparam heads_t PH4 = '{m1: LT_RED,    m2: LT_RED,    mt: LT_RED,    s: LT_GREEN};
    localparam heads_t PH5 = '{m1: LT_RED,    m2: LT_RED,    mt: LT_RED,    s: LT_RED};

    function automatic logic is_onehot(input logic [LW-1:0] code);
        return (code != '0) && ((code & (code - LW'(1))) == '0);
    endfunction

    function automatic logic [2:0] decode_phase(input heads_t h);
        logic [2:0] ph;
        ph = PHASE_NONE;
        if (h == PH0)      ph = 3'd0;
        else if (h == PH1) ph = 3'd1;
        else if (h == PH2) ph = 3'd2;
        else if (h == PH3) ph = 3'd3;
        else if (h == PH4) ph = 3'd4;
        else if (h == PH5) ph = 3'd5;
        return ph;
    endfunction

endpackage

// File: rtl/tl_head_checker.sv
// Per-head checker: code legality, colour-transition legality and yellow duration.
module tl_head_checker
    import tl_pkg::*;
#(
    parameter int unsigned YEL_MIN     = 2,
    parameter int unsigned YEL_MAX     = 4,
    parameter bit          SKIP_YELLOW = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          primed,
    input  logic [LW-1:0] light,
    output logic          illegal_c,
    output logic          trans_c,
    output logic          yel_short_c,
    output logic          yel_long_c,
    output logic          changed_c
);

    localparam int unsigned YCW = $clog2(YEL_MAX + 2);
    localparam logic [YCW-1:0] YEL_SAT = YCW'(YEL_MAX + 1);

    logic [LW-1:0]  prev;
    logic [YCW-1:0] yel_cnt;
    logic [YCW-1:0] yel_cnt_next;
    logic           legal;
    logic           prev_vld;
    logic           was_y;
    logic           step_ok;

    // prev only tracks legal samples, so an illegal glitch never poisons the next transition check
    always_comb begin
        legal        = is_onehot(light);
        prev_vld     = primed && is_onehot(prev);
        was_y        = prev_vld && (prev == LT_YELLOW);
        illegal_c    = !legal;
        changed_c    = 1'b0;
        trans_c      = 1'b0;
        yel_short_c  = 1'b0;
        yel_long_c   = 1'b0;
        yel_cnt_next = yel_cnt;
        step_ok      = (light == prev)
                    || (prev == LT_RED    && light == LT_GREEN)
                    || (prev == LT_GREEN  && light == LT_YELLOW)
                    || (prev == LT_YELLOW && light == LT_RED)
                    || (SKIP_YELLOW && prev == LT_GREEN && light == LT_RED);
        if (legal) begin
            changed_c = prev_vld && (light != prev);
            trans_c   = prev_vld && !step_ok;
            if (light == LT_YELLOW) begin
                if (was_y) begin
                    if (yel_cnt != YEL_SAT) yel_cnt_next = yel_cnt + YCW'(1);
                    yel_long_c = (yel_cnt == YCW'(YEL_MAX));
                end else begin
                    yel_cnt_next = YCW'(1);
                end
            end else begin
                yel_cnt_next = '0;
                yel_short_c  = was_y && (light == LT_RED) && (yel_cnt < YCW'(YEL_MIN));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev    <= '0;
            yel_cnt <= '0;
        end else if (legal) begin
            prev    <= light;
            yel_cnt <= yel_cnt_next;
        end
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// Safety monitor for four light heads: latches the first fault, requests all-red, reports phase.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int unsigned YEL_MIN       = 2,
    parameter int unsigned YEL_MAX       = 4,
    parameter int unsigned STUCK_MAX     = 16,
    parameter bit          S_SKIP_YELLOW = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [LW-1:0] light_M1,
    input  logic [LW-1:0] light_M2,
    input  logic [LW-1:0] light_MT,
    input  logic [LW-1:0] light_S,
    input  logic          clr_fault,
    output logic          fault,
    output logic [2:0]    fault_code,
    output logic [1:0]    fault_head,
    output logic          all_red_req,
    output logic [2:0]    phase_id,
    output logic [7:0]    cycles_done
);

    localparam int unsigned SCW = $clog2(STUCK_MAX + 1);

    logic [NUM_HEADS-1:0][LW-1:0] lights;
    heads_t                       cur;
    logic [NUM_HEADS-1:0]         illegal, trans, yel_short, yel_long, changed;
    logic [NUM_HEADS-1:0]         non_red, conflict;
    logic                         primed;
    logic [SCW-1:0]               stuck_cnt, stuck_cnt_next;
    logic                         stuck_hit;
    fault_e                       det_code;
    logic [1:0]                   det_head;
    logic [2:0]                   phase_next;

    assign lights      = {light_S, light_MT, light_M2, light_M1};
    assign cur         = '{m1: light_M1, m2: light_M2, mt: light_MT, s: light_S};
    assign all_red_req = fault;

    for (genvar h = 0; h < NUM_HEADS; h++) begin : g_head
        tl_head_checker #(
            .YEL_MIN     (YEL_MIN),
            .YEL_MAX     (YEL_MAX),
            .SKIP_YELLOW ((h == 3) && S_SKIP_YELLOW)
        ) u_head (
            .clk         (clk),
            .rst         (rst),
            .primed      (primed),
            .light       (lights[h]),
            .illegal_c   (illegal[h]),
            .trans_c     (trans[h]),
            .yel_short_c (yel_short[h]),
            .yel_long_c  (yel_long[h]),
            .changed_c   (changed[h])
        );
    end

    function automatic logic [1:0] first_set(input logic [NUM_HEADS-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_HEADS - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Fault detection for the current sample, highest-priority code and lowest head first
    always_comb begin
        det_code  = FC_NONE;
        det_head  = 2'd0;
        non_red   = '0;
        conflict  = '0;
        for (int i = 0; i < NUM_HEADS; i++) non_red[i] = (lights[i] != LT_RED);
        conflict[HEAD_MT] = non_red[HEAD_MT] && non_red[HEAD_M2];
        conflict[HEAD_S]  = non_red[HEAD_S]
                         && (non_red[HEAD_M1] || non_red[HEAD_M2] || non_red[HEAD_MT]);
        stuck_cnt_next = stuck_cnt;
        if (|changed)                           stuck_cnt_next = '0;
        else if (stuck_cnt != SCW'(STUCK_MAX))  stuck_cnt_next = stuck_cnt + SCW'(1);
        stuck_hit = !(|changed) && (stuck_cnt == SCW'(STUCK_MAX - 1));
        if (|illegal) begin
            det_code = FC_ILLEGAL;   det_head = first_set(illegal);
        end else if (|conflict) begin
            det_code = FC_CONFLICT;  det_head = first_set(conflict);
        end else if (|trans) begin
            det_code = FC_TRANS;     det_head = first_set(trans);
        end else if (|yel_short) begin
            det_code = FC_YEL_SHORT; det_head = first_set(yel_short);
        end else if (|yel_long) begin
            det_code = FC_YEL_LONG;  det_head = first_set(yel_long);
        end else if (stuck_hit) begin
            det_code = FC_STUCK;     det_head = 2'd0;
        end
        phase_next = decode_phase(cur);
    end

    // A detection in the same sample as clr_fault wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            primed      <= 1'b0;
            stuck_cnt   <= '0;
            fault       <= 1'b0;
            fault_code  <= 3'd0;
            fault_head  <= 2'd0;
            phase_id    <= PHASE_NONE;
            cycles_done <= 8'd0;
        end else begin
            primed    <= 1'b1;
            stuck_cnt <= stuck_cnt_next;
            if ((det_code != FC_NONE) && (!fault || clr_fault)) begin
                fault      <= 1'b1;
                fault_code <= det_code;
                fault_head <= det_head;
            end else if (clr_fault) begin
                fault      <= 1'b0;
                fault_code <= 3'd0;
                fault_head <= 2'd0;
            end
            phase_id <= phase_next;
            if ((phase_next == 3'd0) && (phase_id != 3'd0)) cycles_done <= cycles_done + 8'd1;
        end
    end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench: phase table plus hand-written fault sequences, queue-based scoreboard.
module tb_traffic_light_monitor;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    localparam logic [4:0] M_F = 5'b00001;
    localparam logic [4:0] M_C = 5'b00010;
    localparam logic [4:0] M_H = 5'b00100;
    localparam logic [4:0] M_P = 5'b01000;
    localparam logic [4:0] M_Y = 5'b10000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic       clr_fault;

    logic       f1, ar1, f0, ar0;
    logic [2:0] code1, ph1, code0, ph0;
    logic [1:0] head1, head0;
    logic [7:0] cyc1, cyc0;

    always #5 clk = ~clk;

    traffic_light_monitor #(
        .YEL_MIN(2), .YEL_MAX(4), .STUCK_MAX(16), .S_SKIP_YELLOW(1'b1)
    ) dut_skip (
        .clk(clk), .rst(rst),
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .clr_fault(clr_fault),
        .fault(f1), .fault_code(code1), .fault_head(head1), .all_red_req(ar1),
        .phase_id(ph1), .cycles_done(cyc1)
    );

    traffic_light_monitor #(
        .YEL_MIN(2), .YEL_MAX(4), .STUCK_MAX(16), .S_SKIP_YELLOW(1'b0)
    ) dut_noskip (
        .clk(clk), .rst(rst),
        .light_M1(light_M1), .light_M2(light_M2), .light_MT(light_MT), .light_S(light_S),
        .clr_fault(clr_fault),
        .fault(f0), .fault_code(code0), .fault_head(head0), .all_red_req(ar0),
        .phase_id(ph0), .cycles_done(cyc0)
    );

    typedef struct {
        logic [2:0] m1, m2, mt, s;
        int         reps;
        logic [2:0] phase;
        logic [7:0] cyc;
    } seg_t;

    typedef struct {
        logic       sel;
        logic [4:0] mask;
        logic       fault;
        logic [2:0] code;
        logic [1:0] head;
        logic [2:0] phase;
        logic [7:0] cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t mk(logic sel, logic [4:0] mask, logic f, logic [2:0] c,
                                logic [1:0] h, logic [2:0] p, logic [7:0] y, string nm);
        exp_t e;
        e.sel = sel; e.mask = mask; e.fault = f; e.code = c; e.head = h;
        e.phase = p; e.cyc = y; e.name = nm;
        return e;
    endfunction

    function automatic exp_t nf(logic sel, string nm);
        return mk(sel, M_F | M_C, 1'b0, 3'd0, 2'd0, 3'd0, 8'd0, nm);
    endfunction

    function automatic exp_t flt(logic sel, logic [2:0] c, logic [1:0] h, string nm);
        return mk(sel, M_F | M_C | M_H, 1'b1, c, h, 3'd0, 8'd0, nm);
    endfunction

    task automatic check(string nm, int act, int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic expect_out(exp_t e);
        sb.push_back(e);
    endtask

    // Pop every pending expectation against the outputs registered at the last edge
    task automatic drain();
        while (sb.size() > 0) begin
            exp_t       e;
            logic       f, ar;
            logic [2:0] c, p;
            logic [1:0] h;
            logic [7:0] y;
            e = sb.pop_front();
            if (e.sel) begin f = f1; ar = ar1; c = code1; h = head1; p = ph1; y = cyc1; end
            else       begin f = f0; ar = ar0; c = code0; h = head0; p = ph0; y = cyc0; end
            if (e.mask[0]) begin
                check($sformatf("%s.fault", e.name), int'(f), int'(e.fault));
                check($sformatf("%s.all_red", e.name), int'(ar), int'(e.fault));
            end
            if (e.mask[1]) check($sformatf("%s.code", e.name), int'(c), int'(e.code));
            if (e.mask[2]) check($sformatf("%s.head", e.name), int'(h), int'(e.head));
            if (e.mask[3]) check($sformatf("%s.phase", e.name), int'(p), int'(e.phase));
            if (e.mask[4]) check($sformatf("%s.cycles", e.name), int'(y), int'(e.cyc));
        end
    endtask

    task automatic step(logic [2:0] m1, logic [2:0] m2, logic [2:0] mt, logic [2:0] s, logic clr);
        light_M1 = m1; light_M2 = m2; light_MT = mt; light_S = s; clr_fault = clr;
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic do_reset(string nm);
        rst = 1'b1;
        expect_out(mk(1'b1, M_F | M_C | M_H | M_P | M_Y, 1'b0, 3'd0, 2'd0, 3'd7, 8'd0, nm));
        expect_out(mk(1'b0, M_F | M_C | M_H | M_P | M_Y, 1'b0, 3'd0, 2'd0, 3'd7, 8'd0, nm));
        step(R, R, R, R, 1'b0);
        rst = 1'b0;
    endtask

    seg_t segs [7];

    initial begin
        segs = '{
            '{G, G, R, R, 8, 3'd0, 8'd1},
            '{G, Y, R, R, 3, 3'd1, 8'd1},
            '{G, R, G, R, 6, 3'd2, 8'd1},
            '{Y, R, Y, R, 3, 3'd3, 8'd1},
            '{R, R, R, G, 4, 3'd4, 8'd1},
            '{R, R, R, R, 3, 3'd5, 8'd1},
            '{G, G, R, R, 2, 3'd0, 8'd2}
        };
        rst = 1'b1; clr_fault = 1'b0;
        light_M1 = R; light_M2 = R; light_MT = R; light_S = R;
        @(posedge clk);
        #1;

        // Normal phase sequence
        do_reset("reset");
        foreach (segs[i]) begin
            for (int r = 0; r < segs[i].reps; r++) begin
                expect_out(mk(1'b1, M_F | M_C | M_P | M_Y, 1'b0, 3'd0, 2'd0,
                              segs[i].phase, segs[i].cyc, $sformatf("phase_seg%0d", i)));
                step(segs[i].m1, segs[i].m2, segs[i].mt, segs[i].s, 1'b0);
            end
        end

        // Illegal code, then clear
        do_reset("reset_illegal");
        expect_out(nf(1'b1, "pre_illegal"));        step(G, G, R, R, 1'b0);
        expect_out(flt(1'b1, 3'd1, 2'd0, "illegal_m1")); step(3'b011, G, R, R, 1'b0);
        expect_out(nf(1'b1, "clear_illegal"));      step(G, G, R, R, 1'b1);
        expect_out(nf(1'b1, "stays_clear"));        step(G, G, R, R, 1'b0);

        // Illegal beats a simultaneous conflict
        do_reset("reset_prio");
        expect_out(nf(1'b1, "pre_prio"));           step(G, G, R, R, 1'b0);
        expect_out(flt(1'b1, 3'd1, 2'd1, "illegal_over_conflict")); step(G, 3'b000, R, G, 1'b0);

        // Reset while faulted leaves nothing behind; then bad transition on M2
        do_reset("reset_mid_fault");
        expect_out(nf(1'b1, "pre_trans"));          step(G, G, R, R, 1'b0);
        expect_out(flt(1'b1, 3'd3, 2'd1, "m2_g_to_r")); step(G, R, R, R, 1'b0);

        // S green->red: legal only in the skip-yellow instance
        do_reset("reset_skip");
        expect_out(nf(1'b1, "s_green_skip"));
        expect_out(nf(1'b0, "s_green_noskip"));     step(R, R, R, G, 1'b0);
        expect_out(nf(1'b1, "s_g_to_r_skip"));
        expect_out(flt(1'b0, 3'd3, 2'd3, "s_g_to_r_noskip")); step(R, R, R, R, 1'b0);

        // Yellow too short, then yellow too long reported once
        do_reset("reset_yel");
        expect_out(nf(1'b1, "yel_pre"));            step(G, G, R, R, 1'b0);
        expect_out(nf(1'b1, "yel_one"));            step(G, Y, R, R, 1'b0);
        expect_out(flt(1'b1, 3'd4, 2'd1, "yel_short")); step(G, R, R, R, 1'b0);
        expect_out(nf(1'b1, "clear_short"));        step(G, R, R, R, 1'b1);
        expect_out(nf(1'b1, "mt_green"));           step(G, R, G, R, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            expect_out(nf(1'b1, $sformatf("mt_yel%0d", k))); step(G, R, Y, R, 1'b0);
        end
        expect_out(flt(1'b1, 3'd5, 2'd2, "yel_long")); step(G, R, Y, R, 1'b0);
        expect_out(nf(1'b1, "clear_long"));         step(G, R, Y, R, 1'b1);
        for (int k = 0; k < 2; k++) begin
            expect_out(nf(1'b1, "yel_long_once")); step(G, R, Y, R, 1'b0);
        end

        // Stuck: 15 unchanged samples are fine, the 16th faults, and it is not re-raised
        do_reset("reset_stuck");
        for (int k = 0; k < 15; k++) begin
            expect_out(nf(1'b1, "stuck_wait")); step(G, G, R, R, 1'b0);
        end
        expect_out(mk(1'b1, M_F | M_C, 1'b1, 3'd6, 2'd0, 3'd0, 8'd0, "stuck")); step(G, G, R, R, 1'b0);
        expect_out(nf(1'b1, "clear_stuck"));        step(G, G, R, R, 1'b1);
        expect_out(nf(1'b1, "stuck_once"));         step(G, G, R, R, 1'b0);

        // Clear loses to a fault in the same sample; rule B conflict
        do_reset("reset_clr");
        expect_out(nf(1'b1, "clr_pre"));            step(G, G, R, R, 1'b0);
        expect_out(flt(1'b1, 3'd1, 2'd0, "clr_first")); step(3'b011, G, R, R, 1'b0);
        expect_out(flt(1'b1, 3'd2, 2'd3, "clr_loses")); step(G, G, R, G, 1'b1);
        expect_out(nf(1'b1, "clr_wins"));           step(G, G, R, R, 1'b1);
        expect_out(flt(1'b1, 3'd2, 2'd2, "rule_b")); step(G, G, G, R, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
